// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell is reused LSB first over WIDTH cycles, then the
// result is held in DONE until the consumer takes it.

module serial_add_fa_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic xy_x;
    logic xy_a;
    logic xc_a;

    assign xy_x = x_i ^ y_i;
    assign xy_a = x_i & y_i;
    assign xc_a = xy_x & c_i;
    assign s_o  = xy_x ^ c_i;
    assign c_o  = xy_a | xc_a;
endmodule

module serial_add_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam bit HasPen = (WIDTH > 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] PenCnt = CntW'(HasPen ? WIDTH - 2 : 0);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cmsb_q, cmsb_d;
    logic              carryout_q, carryout_d;
    logic              overflow_q, overflow_d;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  bit_mask;
    logic              fa_s;
    logic              fa_co;

    assign a_sh     = a_q >> cnt_q;
    assign b_sh     = b_q >> cnt_q;
    assign bit_mask = WIDTH'(1) << cnt_q;

    serial_add_fa_cell u_fa (
        .x_i (a_sh[0]),
        .y_i (b_sh[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_co)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        cmsb_d       = cmsb_q;
        carryout_d   = carryout_q;
        overflow_d   = overflow_q;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carryin;
                    // With WIDTH=1 the captured carryin is already the carry into the MSB.
                    cmsb_d  = carryin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                sum_d   = fa_s ? (sum_q | bit_mask) : (sum_q & ~bit_mask);
                carry_d = fa_co;
                cnt_d   = cnt_q + CntW'(1);
                if (HasPen && (cnt_q == PenCnt)) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == LastCnt) begin
                    carryout_d = fa_co;
                    overflow_d = cmsb_q ^ fa_co;
                    state_d    = StDone;
                end
            end
            StDone: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cmsb_q     <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            cmsb_q     <= cmsb_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
        end
    end

    assign sum      = sum_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=8: latency, handshakes, reset and
// back-to-back throughput.

module tb_serial_add_sequencer;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .carryin      (carryin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum          (sum),
        .carryout     (carryout),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic [7:0] exp_sum, input logic exp_co,
                          input logic exp_ov, input int hold);
        int n;
        int busy_cnt;
        check({tag, " ready"}, start_ready, 1'b1);
        a = av;
        b = bv;
        carryin = civ;
        start_valid = 1'b1;
        result_ready = 1'b0;
        tick();
        start_valid = 1'b0;
        a = ~av;
        b = ~bv;
        carryin = ~civ;
        n = 0;
        busy_cnt = 0;
        while (!result_valid && n < 20) begin
            if (busy) busy_cnt++;
            result_ready = 1'b1;
            start_valid = n[0];
            tick();
            n++;
        end
        start_valid = 1'b0;
        result_ready = 1'b0;
        check({tag, " latency"}, n + 1, 9);
        check({tag, " busy_cycles"}, busy_cnt, 8);
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " carryout"}, carryout, exp_co);
        check({tag, " overflow"}, overflow, exp_ov);
        for (int i = 0; i < hold; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            start_valid = 1'b1;
            tick();
            check({tag, " hold_valid"}, result_valid, 1'b1);
            check({tag, " hold_ready"}, start_ready, 1'b0);
            check({tag, " hold_sum"}, {overflow, carryout, sum}, {exp_ov, exp_co, exp_sum});
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, " idle_valid"}, result_valid, 1'b0);
        check({tag, " idle_ready"}, start_ready, 1'b1);
        check({tag, " idle_kept"}, {overflow, carryout, sum}, {exp_ov, exp_co, exp_sum});
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       qc[$];

    initial begin
        logic [8:0] ref_full;
        logic [7:0] ea, eb;
        logic       ec, eov;
        int         cyc, last, got;

        reset_n = 1'b0;
        start_valid = 1'b1;
        result_ready = 1'b0;
        a = 8'h12;
        b = 8'h34;
        carryin = 1'b1;
        tick();
        tick();
        check("rst busy", busy, 1'b0);
        check("rst ready", start_ready, 1'b1);
        check("rst valid", result_valid, 1'b0);
        check("rst outs", {overflow, carryout, sum}, 10'h0);
        start_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check("rst no_accept", busy, 1'b0);

        run_op("c1", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        run_op("c2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("c2b", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op("c3a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op("c3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        run_op("c3c", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op("c4", 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1, 5);

        // Reset during RUN cycle 3.
        a = 8'h55;
        b = 8'h11;
        carryin = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("c5 busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("c5 busy", busy, 1'b0);
        check("c5 ready", start_ready, 1'b1);
        check("c5 valid", result_valid, 1'b0);
        check("c5 outs", {overflow, carryout, sum}, 10'h0);
        run_op("c5", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        // Back-to-back with both handshakes held high.
        start_valid = 1'b1;
        result_ready = 1'b1;
        cyc = 0;
        last = -1;
        got = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        carryin = 1'($urandom);
        qa.push_back(a);
        qb.push_back(b);
        qc.push_back(carryin);
        while (got < 6 && cyc < 200) begin
            tick();
            cyc++;
            if (result_valid) begin
                if (qa.size() == 0) begin
                    check("c6 unexpected_result", 1'b1, 1'b0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    ec = qc.pop_front();
                    ref_full = {1'b0, ea} + {1'b0, eb} + {8'h0, ec};
                    eov = (ea[7] == eb[7]) && (ref_full[7] != ea[7]);
                    check("c6 result", {overflow, carryout, sum}, {eov, ref_full});
                end
                if (last >= 0) check("c6 interval", cyc - last, 10);
                last = cyc;
                got++;
            end
            if (start_ready) begin
                a = 8'($urandom);
                b = 8'($urandom);
                carryin = 1'($urandom);
                qa.push_back(a);
                qb.push_back(b);
                qc.push_back(carryin);
            end
        end
        check("c6 count", got, 6);
        start_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("c6 drained_ready", start_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
